// File: rtl/PARAMS_pkg.sv
// Shared widths and enums for the memory arbiter: FSM states and access owner.
package PARAMS_pkg;

  localparam int WD_SIZE    = 32;
  localparam int INSTR_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between a fetch (i_*) and a data (d_*) requester.
// Optional MEM_ARB_STARVE_GUARD_EN bounds how long fetch can be starved by data.
module mem_arbiter
  import PARAMS_pkg::*;
#(
  parameter int ADDR_W     = INSTR_SIZE,
  parameter int DATA_W     = WD_SIZE,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_kill,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_rd_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_op_en,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic              rd_wr_q, rd_wr_d;
  logic [2:0]        wait_cnt_q, wait_cnt_d;
  logic              kill_q, kill_d;
  logic              mem_op_en_q, mem_op_en_d;
  logic              mem_rd_wr_q, mem_rd_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
  logic              i_ack_q, i_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic              data_wins;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  logic [2:0] starve_q, starve_d;

  // Counter counts data grants that overtook a waiting fetch; at the limit fetch wins once.
  always_comb begin
    data_wins = d_req && !(i_req && (starve_q == STARVE_LIM));
    starve_d  = starve_q;
    if ((state_q == IDLE) && (i_req || d_req)) begin
      if (!data_wins) begin
        starve_d = '0;
      end else if (i_req) begin
        starve_d = starve_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve;
  assign data_wins     = d_req;
  assign unused_starve = ^3'(STARVE_MAX);
`endif

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rd_wr_d       = rd_wr_q;
    wait_cnt_d    = wait_cnt_q;
    kill_d        = kill_q;
    mem_op_en_d   = 1'b0;
    mem_rd_wr_d   = mem_rd_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    i_ack_d       = 1'b0;
    i_rdata_d     = i_rdata_q;
    d_ack_d       = 1'b0;
    d_rdata_d     = d_rdata_q;
    busy_d        = busy_q;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d     = ISSUE;
          busy_d      = 1'b1;
          kill_d      = 1'b0;
          mem_op_en_d = 1'b1;
          if (data_wins) begin
            owner_d       = OWN_D;
            rd_wr_d       = d_rd_wr;
            mem_rd_wr_d   = d_rd_wr;
            mem_addr_d    = d_addr;
            mem_wr_data_d = d_wdata;
          end else begin
            owner_d       = OWN_I;
            rd_wr_d       = 1'b0;
            mem_rd_wr_d   = 1'b0;
            mem_addr_d    = i_addr;
            mem_wr_data_d = '0;
          end
        end
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = 3'd1;
        if ((owner_q == OWN_I) && i_kill) kill_d = 1'b1;
      end
      WAIT: begin
        if ((owner_q == OWN_I) && i_kill) kill_d = 1'b1;
        if (wait_cnt_q == LAT) begin
          // Last wait cycle: memory data is valid now, so the ack is formed here.
          state_d = RESP;
          if (owner_q == OWN_D) begin
            d_ack_d   = 1'b1;
            d_rdata_d = rd_wr_q ? '0 : mem_rd_data;
          end else if (!(kill_q || i_kill)) begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rd_data;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= OWN_I;
      rd_wr_q       <= 1'b0;
      wait_cnt_q    <= '0;
      kill_q        <= 1'b0;
      mem_op_en_q   <= 1'b0;
      mem_rd_wr_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      i_ack_q       <= 1'b0;
      i_rdata_q     <= '0;
      d_ack_q       <= 1'b0;
      d_rdata_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rd_wr_q       <= rd_wr_d;
      wait_cnt_q    <= wait_cnt_d;
      kill_q        <= kill_d;
      mem_op_en_q   <= mem_op_en_d;
      mem_rd_wr_q   <= mem_rd_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      i_ack_q       <= i_ack_d;
      i_rdata_q     <= i_rdata_d;
      d_ack_q       <= d_ack_d;
      d_rdata_q     <= d_rdata_d;
      busy_q        <= busy_d;
    end
  end

  assign i_ack       = i_ack_q;
  assign i_rdata     = i_rdata_q;
  assign d_ack       = d_ack_q;
  assign d_rdata     = d_rdata_q;
  assign mem_op_en   = mem_op_en_q;
  assign mem_rd_wr   = mem_rd_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: latency-accurate memory model, ack scoreboard and
// scenario tasks. Grant-order expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 1;
  localparam int SMAX = 4;

  logic          clk;
  logic          reset;
  logic          i_req, i_kill, i_ack;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_rd_wr, d_ack;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_op_en, mem_rd_wr, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_i_q[$];
  logic [DW-1:0] exp_d_q[$];
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] mem_model[logic [AW-1:0]];

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_rd_wr(d_rd_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_op_en(mem_op_en), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Memory model: read data is valid only during cycle T+LAT, junk otherwise.
  initial begin
    int            lat_cnt;
    logic [DW-1:0] pend;
    lat_cnt     = 0;
    pend        = '0;
    mem_rd_data = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_rd_data = $urandom;
      if (mem_op_en === 1'b1) begin
        addr_log.push_back(mem_addr);
        if (mem_rd_wr) begin
          mem_model[mem_addr] = mem_wr_data;
          pend = $urandom;
        end else begin
          pend = model_read(mem_addr);
        end
        lat_cnt = LAT;
      end else if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) mem_rd_data = pend;
      end
    end
  end

  // Scoreboard: every ack pops and compares the oldest expectation.
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (i_ack === 1'b1) begin
        checks++;
        if (exp_i_q.size() == 0) begin
          errors++;
          $display("FAIL i_ack_unexpected: got i_ack=1 i_rdata=%h, expected no ack", i_rdata);
        end else begin
          e = exp_i_q.pop_front();
          if (i_rdata !== e) begin
            errors++;
            $display("FAIL i_rdata: got %h expected %h", i_rdata, e);
          end
        end
      end
      if (d_ack === 1'b1) begin
        checks++;
        if (exp_d_q.size() == 0) begin
          errors++;
          $display("FAIL d_ack_unexpected: got d_ack=1 d_rdata=%h, expected no ack", d_rdata);
        end else begin
          e = exp_d_q.pop_front();
          if (d_rdata !== e) begin
            errors++;
            $display("FAIL d_rdata: got %h expected %h", d_rdata, e);
          end
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fetch(input logic [AW-1:0] a);
    i_req  = 1'b1;
    i_addr = a;
    exp_i_q.push_back(model_read(a));
  endtask

  task automatic drive_data(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    d_req   = 1'b1;
    d_rd_wr = wr;
    d_addr  = a;
    d_wdata = wd;
    exp_d_q.push_back(wr ? '0 : model_read(a));
  endtask

  task automatic wait_ack(input logic want_d, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(want_d ? (d_ack === 1'b1) : (i_ack === 1'b1)) && waited < 40);
    if (!(want_d ? (d_ack === 1'b1) : (i_ack === 1'b1))) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no %s ack within %0d cycles", want_d ? "d" : "i", waited);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({mem_op_en, mem_rd_wr, mem_addr, mem_wr_data, i_ack, i_rdata, d_ack, d_rdata, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got op=%b rw=%b addr=%h wd=%h ia=%b ir=%h da=%b dr=%h busy=%b expected all 0",
               mem_op_en, mem_rd_wr, mem_addr, mem_wr_data, i_ack, i_rdata, d_ack, d_rdata, busy);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || mem_op_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b op=%b expected 0 0", busy, mem_op_en);
    end
  endtask

  task automatic test_fetch_read();
    mem_model[32'h10] = 32'hDEADBEEF;
    drive_fetch(32'h10);
    tick();
    checks++;
    if (mem_op_en !== 1'b1 || mem_addr !== 32'h10 || mem_rd_wr !== 1'b0 || mem_wr_data !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_issue: got op=%b addr=%h rw=%b wd=%h busy=%b expected 1 00000010 0 0 1",
               mem_op_en, mem_addr, mem_rd_wr, mem_wr_data, busy);
    end
    tick();
    checks++;
    if (mem_op_en !== 1'b0 || mem_addr !== 32'h10 || i_ack !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait: got op=%b addr=%h ack=%b expected 0 00000010 0", mem_op_en, mem_addr, i_ack);
    end
    repeat (LAT) tick();
    checks++;
    if (i_ack !== 1'b1 || i_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fetch_ack: got ack=%b data=%h expected 1 deadbeef", i_ack, i_rdata);
    end
    i_req = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || i_ack !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done: got busy=%b ack=%b expected 0 0", busy, i_ack);
    end
  endtask

  task automatic test_data_write();
    drive_data(1'b1, 32'h40, 32'h12345678);
    tick();
    checks++;
    if (mem_op_en !== 1'b1 || mem_rd_wr !== 1'b1 || mem_wr_data !== 32'h12345678 || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL write_issue: got op=%b rw=%b wd=%h addr=%h expected 1 1 12345678 00000040",
               mem_op_en, mem_rd_wr, mem_wr_data, mem_addr);
    end
    repeat (LAT + 1) tick();
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== '0) begin
      errors++;
      $display("FAIL write_ack: got ack=%b data=%h expected 1 0", d_ack, d_rdata);
    end
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_data_read();
    int w;
    drive_data(1'b0, 32'h40, 32'hFFFF_FFFF);
    wait_ack(1'b1, w);
    d_req = 1'b0;
    checks++;
    if (w != LAT + 2) begin
      errors++;
      $display("FAIL read_latency: got %0d cycles expected %0d", w, LAT + 2);
    end
    tick();
  endtask

  task automatic test_contention();
    logic          done_d, done_i;
    logic [AW-1:0] exp_a;
    int            cyc;
    addr_log.delete();
    done_d = 1'b0;
    done_i = 1'b0;
    cyc    = 0;
    drive_fetch(32'h100);
    drive_data(1'b0, 32'h200, '0);
    while (!(done_d && done_i) && cyc < 400) begin
      tick();
      cyc++;
      if (d_ack === 1'b1) begin
        if (addr_log.size() >= 10) begin
          d_req  = 1'b0;
          done_d = 1'b1;
        end else begin
          drive_data(1'b0, 32'h200, '0);
        end
      end
      if (i_ack === 1'b1) begin
        if (done_d) begin
          i_req  = 1'b0;
          done_i = 1'b1;
        end else begin
          drive_fetch(32'h100);
        end
      end
    end
    if (!(done_d && done_i)) begin
      checks++;
      errors++;
      $display("FAIL contention_timeout: got done_d=%b done_i=%b after %0d cycles expected both 1", done_d, done_i, cyc);
      d_req = 1'b0;
      i_req = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_a = ((k % (SMAX + 1)) == SMAX) ? 32'h100 : 32'h200;
`else
      exp_a = 32'h200;
`endif
      checks++;
      if (k >= addr_log.size()) begin
        errors++;
        $display("FAIL grant_order[%0d]: got no grant expected addr %h", k, exp_a);
      end else if (addr_log[k] !== exp_a) begin
        errors++;
        $display("FAIL grant_order[%0d]: got addr %h expected %h", k, addr_log[k], exp_a);
      end
    end
    tick();
  endtask

  task automatic test_kill();
    for (int kc = 1; kc <= LAT + 1; kc++) begin
      i_req  = 1'b1;
      i_addr = 32'h80 + 32'(kc);
      i_kill = 1'b0;
      for (int c = 1; c <= LAT + 2; c++) begin
        tick();
        if (c == 1) begin
          checks++;
          if (mem_op_en !== 1'b1) begin
            errors++;
            $display("FAIL kill_issue[%0d]: got op=%b expected 1", kc, mem_op_en);
          end
        end
        if (c == LAT + 2) begin
          checks++;
          if (i_ack !== 1'b0) begin
            errors++;
            $display("FAIL kill_suppress[%0d]: got i_ack=%b expected 0", kc, i_ack);
          end
        end
        i_kill = (c == kc);
        if (c == kc) i_req = 1'b0;
      end
      i_kill = 1'b0;
      i_req  = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL kill_idle[%0d]: got busy=%b expected 0", kc, busy);
      end
    end
  endtask

  task automatic test_kill_no_effect();
    int w;
    i_kill = 1'b1;
    drive_fetch(32'hA0);
    tick();
    i_kill = 1'b0;
    wait_ack(1'b0, w);
    i_req = 1'b0;
    tick();
    i_kill = 1'b1;
    drive_data(1'b0, 32'hB0, '0);
    wait_ack(1'b1, w);
    d_req  = 1'b0;
    i_kill = 1'b0;
    tick();
  endtask

  task automatic test_dropped_request();
    int w;
    drive_data(1'b0, 32'h300, '0);
    tick();
    d_req = 1'b0;
    wait_ack(1'b1, w);
    checks++;
    if (w + 1 != LAT + 2) begin
      errors++;
      $display("FAIL dropped_latency: got %0d cycles expected %0d", w + 1, LAT + 2);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int acks;
    i_req  = 1'b1;
    i_addr = 32'h90;
    tick();
    tick();
    reset = 1'b1;
    i_req = 1'b0;
    tick();
    checks++;
    if ({mem_op_en, mem_rd_wr, mem_addr, mem_wr_data, i_ack, i_rdata, d_ack, d_rdata, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got op=%b addr=%h ia=%b ir=%h busy=%b expected all 0",
               mem_op_en, mem_addr, i_ack, i_rdata, busy);
    end
    reset = 1'b0;
    acks  = 0;
    repeat (6) begin
      tick();
      if (i_ack === 1'b1 || d_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL reset_mid_ack: got %0d acks expected 0", acks);
    end
  endtask

  task automatic test_back_to_back();
    int            w, kind;
    logic [AW-1:0] a;
    logic          prev_d;
    prev_d = 1'b0;
    for (int n = 0; n < 12; n++) begin
      kind = $urandom_range(0, 2);
      a    = 32'h400 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      // New request is raised in the ack cycle of the previous one.
      if (prev_d) d_req = 1'b0; else i_req = 1'b0;
      if (kind == 0) drive_fetch(a);
      else drive_data(kind == 2, a, $urandom);
      prev_d = (kind != 0);
      wait_ack(prev_d, w);
      if (n > 0) begin
        checks++;
        if (w != LAT + 3) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles expected %0d", n, w, LAT + 3);
        end
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset   = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    i_kill  = 1'b0;
    d_req   = 1'b0;
    d_rd_wr = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    test_reset();
    test_fetch_read();
    test_data_write();
    test_data_read();
    test_contention();
    test_kill();
    test_kill_no_effect();
    test_dropped_request();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_i_q.size() != 0 || exp_d_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding: got %0d fetch and %0d data expectations left, expected 0 0",
               exp_i_q.size(), exp_d_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
